sobel_edge_filter: RTL and testbench

- Stage directly downstream of the Bayer-to-gray converter in the camera pipeline.
- Consumes the raster-order 12-bit gray pixel stream and produces a 3x3 Sobel gradient magnitude per pixel for the display/VGA path.
- Buffers two previous lines internally and runs a fixed-latency pipeline with no backpressure.

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sobel_line_buffer.sv | 22 ++
 rtl/sobel_edge_filter.sv | 153 +++++++++++++++
 tb/tb_sobel_edge_filter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge stage.
package sobel_pkg;
  localparam int PIX_W   = 12;
  localparam int MAG_W   = 15;
  localparam int COORD_W = 16;

  typedef logic [PIX_W-1:0]          pix_t;
  typedef logic [MAG_W-1:0]          mag_t;
  typedef logic signed [MAG_W-1:0]   grad_t;
  typedef logic [COORD_W-1:0]        coord_t;

  localparam pix_t PIX_MAX = 12'hFFF;

  // Per-output bookkeeping carried alongside the valid pipeline.
  typedef struct packed {
    logic   border;
    coord_t row;
    coord_t col;
  } meta_t;

  function automatic mag_t abs_grad(input grad_t g);
    return (g < 0) ? mag_t'(-g) : mag_t'(g);
  endfunction
endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: registered read, read-before-write on a shared address.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output pix_t          rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pix_t          wr_data
);
  pix_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/sobel_edge_filter.sv
// 3x3 Sobel gradient magnitude over a raster gray stream, 3-cycle latency.
// Define SOBEL_THRESH_EN to binarise the magnitude against THRESH.
module sobel_edge_filter
  import sobel_pkg::*;
#(
  parameter int   IMG_W  = 640,
  parameter int   IMG_H  = 480,
  parameter pix_t THRESH = 12'd256
) (
  input  logic   clk,
  input  logic   rst,
  input  pix_t   gray_pixel,
  input  logic   gray_pixel_valid,
  input  logic   sof,
  output pix_t   edge_pixel,
  output logic   edge_pixel_valid,
  output coord_t edge_col,
  output coord_t edge_row
);
  localparam int     STAGES   = 2;
  localparam int     AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam coord_t COL_LAST = coord_t'(IMG_W - 1);
  localparam coord_t ROW_LAST = coord_t'(IMG_H - 1);

  coord_t row_q, col_q, cur_row, cur_col;
  logic   emit;
  meta_t  meta_in;

  always_comb begin
    cur_row        = sof ? '0 : row_q;
    cur_col        = sof ? '0 : col_q;
    emit           = gray_pixel_valid && (cur_row != '0) && (cur_col != '0);
    meta_in.border = (cur_row == coord_t'(1)) || (cur_col == coord_t'(1));
    meta_in.row    = cur_row - 1'b1;
    meta_in.col    = cur_col - 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (gray_pixel_valid) begin
      if (cur_col == COL_LAST) begin
        col_q <= '0;
        row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end

  // LB1 takes the LB0 word one cycle later, so a plain registered-read RAM suffices.
  pix_t          lb0_q, lb1_q, pix_s0;
  logic          acc_s0;
  logic [AW-1:0] col_s0;

  sobel_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .rd_en(gray_pixel_valid), .rd_addr(cur_col[AW-1:0]), .rd_data(lb0_q),
    .wr_en(gray_pixel_valid), .wr_addr(cur_col[AW-1:0]), .wr_data(gray_pixel)
  );

  sobel_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .rd_en(gray_pixel_valid), .rd_addr(cur_col[AW-1:0]), .rd_data(lb1_q),
    .wr_en(acc_s0), .wr_addr(col_s0), .wr_data(lb0_q)
  );

  logic [STAGES:0]           vld_pipe;
  meta_t [STAGES:0]          meta_pipe;
  logic [2:0][2:0][PIX_W-1:0] win;   // win[row][col], row 0 = top, col 0 = left
  mag_t                      abs_x, abs_y;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_s0    <= 1'b0;
      pix_s0    <= '0;
      col_s0    <= '0;
      vld_pipe  <= '0;
      meta_pipe <= '0;
    end else begin
      acc_s0    <= gray_pixel_valid;
      vld_pipe  <= {vld_pipe[STAGES-1:0], emit};
      meta_pipe <= {meta_pipe[STAGES-1:0], meta_in};
      if (gray_pixel_valid) begin
        pix_s0 <= gray_pixel;
        col_s0 <= cur_col[AW-1:0];
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) win <= '0;
    else if (acc_s0) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb1_q;
      win[1][2] <= lb0_q;
      win[2][2] <= pix_s0;
    end

  logic [13:0] sum_l, sum_r, sum_t, sum_b;
  grad_t       gx, gy;

  always_comb begin
    sum_l = 14'(win[0][0]) + 14'({win[1][0], 1'b0}) + 14'(win[2][0]);
    sum_r = 14'(win[0][2]) + 14'({win[1][2], 1'b0}) + 14'(win[2][2]);
    sum_t = 14'(win[0][0]) + 14'({win[0][1], 1'b0}) + 14'(win[0][2]);
    sum_b = 14'(win[2][0]) + 14'({win[2][1], 1'b0}) + 14'(win[2][2]);
    gx    = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
    gy    = $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      abs_x <= '0;
      abs_y <= '0;
    end else if (vld_pipe[1]) begin
      abs_x <= abs_grad(gx);
      abs_y <= abs_grad(gy);
    end

  mag_t mag;
  pix_t result;

  always_comb begin
    mag = abs_x + abs_y;
`ifdef SOBEL_THRESH_EN
    result = (mag >= mag_t'(THRESH)) ? PIX_MAX : '0;
`else
    result = (mag > mag_t'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
`endif
  end

`ifndef SOBEL_THRESH_EN
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      edge_pixel       <= '0;
      edge_pixel_valid <= 1'b0;
      edge_col         <= '0;
      edge_row         <= '0;
    end else begin
      edge_pixel_valid <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        edge_pixel <= meta_pipe[STAGES].border ? '0 : result;
        edge_col   <= meta_pipe[STAGES].col;
        edge_row   <= meta_pipe[STAGES].row;
      end
    end
endmodule

// File: tb/tb_sobel_edge_filter.sv
// Directed bench for sobel_edge_filter on an 8x6 image (flat, step, ramp, mid-frame reset).
module tb_sobel_edge_filter;
  import sobel_pkg::*;

  localparam int   W    = 8;
  localparam int   H    = 6;
  localparam int   NOUT = (W - 1) * (H - 1);
  localparam pix_t TH   = 12'd50;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  pix_t   gray_pixel = '0;
  logic   gray_pixel_valid = 1'b0;
  logic   sof = 1'b0;
  pix_t   edge_pixel;
  logic   edge_pixel_valid;
  coord_t edge_col, edge_row;

  sobel_edge_filter #(.IMG_W(W), .IMG_H(H), .THRESH(TH)) dut (
    .clk(clk), .rst(rst),
    .gray_pixel(gray_pixel), .gray_pixel_valid(gray_pixel_valid), .sof(sof),
    .edge_pixel(edge_pixel), .edge_pixel_valid(edge_pixel_valid),
    .edge_col(edge_col), .edge_row(edge_row)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int row;
    int col;
    int cyc;
  } obs_t;
  obs_t out_q[$];

  always @(negedge clk)
    if (!rst && edge_pixel_valid)
      out_q.push_back('{int'(edge_pixel), int'(edge_row), int'(edge_col), cyc});

  int acc_cyc[W*H];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 0 = flat 100, 1 = vertical step at col 4, 2 = ramp col*10
  function automatic pix_t pix_of(input int pat, input int c);
    case (pat)
      0:       return pix_t'(100);
      1:       return (c >= 4) ? 12'hFFF : 12'h000;
      default: return pix_t'(c * 10);
    endcase
  endfunction

  function automatic int exp_of(input int pat, input int cr, input int cc);
    int mag;
    if (cr == 0 || cc == 0) return 0;
    case (pat)
      0:       mag = 0;
      1:       mag = (cc == 3 || cc == 4) ? 16380 : 0;
      default: mag = 80;
    endcase
`ifdef SOBEL_THRESH_EN
    return (mag >= int'(TH)) ? 4095 : 0;
`else
    return (mag > 4095) ? 4095 : mag;
`endif
  endfunction

  task automatic drive_frame(input int pat, input bit gap, input int stop_row);
    for (int r = 0; r < H && r != stop_row; r++)
      for (int c = 0; c < W; c++) begin
        @(negedge clk);
        gray_pixel       = pix_of(pat, c);
        gray_pixel_valid = 1'b1;
        sof              = (r == 0 && c == 0);
        acc_cyc[r*W+c]   = cyc + 1;
        if (gap) begin
          @(negedge clk);
          gray_pixel_valid = 1'b0;
          sof              = 1'b1;   // must be ignored without valid
          gray_pixel       = pix_t'($urandom);
        end
      end
    @(negedge clk);
    gray_pixel_valid = 1'b0;
    sof              = 1'b0;
  endtask

  task automatic check_frame(input int pat, input string name);
    int idx;
    repeat (8) @(negedge clk);
    check({name, "_count"}, out_q.size(), NOUT);
    idx = 0;
    for (int r = 1; r < H; r++)
      for (int c = 1; c < W; c++) begin
        if (idx < out_q.size()) begin
          check({name, "_val"}, out_q[idx].val, exp_of(pat, r - 1, c - 1));
          check({name, "_row"}, out_q[idx].row, r - 1);
          check({name, "_col"}, out_q[idx].col, c - 1);
          check({name, "_lat"}, out_q[idx].cyc, acc_cyc[r*W+c] + 3);
        end
        idx++;
      end
    out_q.delete();
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      gray_pixel       = pix_t'($urandom);
      gray_pixel_valid = 1'($urandom);
      sof              = 1'($urandom);
    end
    @(negedge clk);
    check("rst_pixel", edge_pixel, 0);
    check("rst_valid", edge_pixel_valid, 0);
    check("rst_col", edge_col, 0);
    check("rst_row", edge_row, 0);
    gray_pixel_valid = 1'b0;
    sof              = 1'b0;
    rst              = 1'b0;
    out_q.delete();

    drive_frame(0, 1'b0, H);
    check_frame(0, "flat");
    check("flat_hold_row", edge_row, 4);
    check("flat_hold_col", edge_col, 6);
    check("flat_hold_valid", edge_pixel_valid, 0);

    drive_frame(1, 1'b0, H);
    check_frame(1, "step");

    drive_frame(2, 1'b0, H);
    check_frame(2, "ramp");

    drive_frame(2, 1'b1, H);
    check_frame(2, "ramp_gap");

    // Abort a frame at row 3 with a reset pulse, then restart cleanly.
    drive_frame(1, 1'b0, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_valid", edge_pixel_valid, 0);
    check("mrst_pixel", edge_pixel, 0);
    out_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst_stale", out_q.size(), 0);
    drive_frame(2, 1'b0, H);
    check_frame(2, "mrst_ramp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
